// File: rtl/trafficmonitor_pkg.sv
// Shared types and width helpers for the multi-channel traffic monitor.
package trafficmonitor_pkg;

    // Window sequence number width (wraps at 2^16).
    localparam int WIN_ID_W   = 16;
    // Storage widths of a buffered sample. The channel index covers up to
    // 16 channels; per-channel counts are held zero-extended to 32 bits,
    // so CNT_W must not exceed CNT_W_MAX.
    localparam int CHAN_W_MAX = 4;
    localparam int CNT_W_MAX  = 32;

    // Behaviour when a sample arrives at a full buffer.
    typedef enum logic {
        DROP_NEWEST      = 1'b0,
        OVERWRITE_OLDEST = 1'b1
    } drop_mode_e;

    // Drain sequencer states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_e;

    // One buffered sample: one channel's flit count for one window.
    typedef struct packed {
        logic [CHAN_W_MAX-1:0] chan;
        logic [CNT_W_MAX-1:0]  count;
        logic [WIN_ID_W-1:0]   win_id;
    } sample_t;

    localparam int SAMPLE_W = $bits(sample_t);

    // Channel index width, never below one bit.
    function automatic int chan_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // Ring pointer width, never below one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/trafficmonitor_mc_ring_buf.sv
// Power-of-two ring buffer with first-word-fall-through read and a
// selectable full policy (drop newest or overwrite oldest).
module sample_ring_buf
    import trafficmonitor_pkg::*;
#(
    parameter int         DEPTH = 64,
    parameter int         WIDTH = SAMPLE_W,
    parameter drop_mode_e MODE  = DROP_NEWEST,
    localparam int        PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   fill_level,
    output logic             drop
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W:0]   fill_r;
    logic             pop_ok_s;
    logic             write_s;
    logic             adv_head_s;

    assign full       = (fill_r == (PTR_W+1)'(DEPTH));
    assign empty      = (fill_r == {(PTR_W+1){1'b0}});
    assign fill_level = fill_r;
    assign rd_data    = mem_r[head_r];

    // Decide whether this cycle stores the push, advances the head, or drops.
    always_comb begin
        pop_ok_s   = pop && !empty;
        write_s    = 1'b0;
        adv_head_s = 1'b0;
        drop       = 1'b0;
        if (push && full && !pop_ok_s) begin
            // Full with no room freed: overwrite mode evicts the oldest slot.
            drop       = 1'b1;
            write_s    = (MODE == OVERWRITE_OLDEST);
            adv_head_s = (MODE == OVERWRITE_OLDEST);
        end else begin
            write_s    = push;
            adv_head_s = pop_ok_s;
        end
    end

    // Sample storage; cleared on reset so no stale window survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (write_s) begin
            mem_r[tail_r] <= push_data;
        end
    end

    // Head/tail pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {PTR_W{1'b0}};
            tail_r <= {PTR_W{1'b0}};
            fill_r <= {(PTR_W+1){1'b0}};
        end else begin
            if (write_s) begin
                tail_r <= tail_r + PTR_W'(1);
            end
            if (adv_head_s) begin
                head_r <= head_r + PTR_W'(1);
            end
            if (write_s && !adv_head_s) begin
                fill_r <= fill_r + (PTR_W+1)'(1);
            end else if (!write_s && adv_head_s) begin
                fill_r <= fill_r - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/trafficmonitor_mc.sv
// Multi-channel NoC traffic monitor: per-channel flit counts over fixed
// windows, drained into a ring buffer read as a valid/ready stream, plus
// an inter-event interval counter.
module trafficmonitor_mc
    import trafficmonitor_pkg::*;
#(
    parameter int  CHANNELS  = 4,
    parameter int  CNT_W     = 16,
    parameter int  WINDOW    = 50,
    parameter int  DEPTH     = 64,
    parameter int  EV_CNT_W  = 32,
    parameter int  OVERWRITE = 0,
    localparam int CHAN_W    = chan_w(CHANNELS),
    localparam int PTR_W     = ptr_w(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                event_global,
    input  logic [CHANNELS-1:0] flit_valid,
    output logic [EV_CNT_W-1:0] ev_counter,
    output logic [EV_CNT_W-1:0] ev_interval,
    output logic                ev_interval_valid,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic [CNT_W-1:0]    smp_data,
    output logic [CHAN_W-1:0]   smp_chan,
    output logic [15:0]         smp_win_id,
    output logic [PTR_W:0]      fill_level,
    output logic                overflow,
    output logic [15:0]         drop_count,
    input  logic                clr_overflow
);

    localparam int                WIN_CNT_W = $clog2(WINDOW + 1);
    localparam drop_mode_e        MODE      = (OVERWRITE != 0) ? OVERWRITE_OLDEST : DROP_NEWEST;
    localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(CHANNELS - 1);

    logic [WIN_CNT_W-1:0] win_cnt_r;
    logic [CNT_W-1:0]     acc_r    [CHANNELS];
    logic [CNT_W-1:0]     shadow_r [CHANNELS];
    logic [WIN_ID_W-1:0]  win_id_r;
    logic [WIN_ID_W-1:0]  shadow_win_id_r;
    logic                 snapshot_s;

    drain_state_e         state_r;
    logic [CHAN_W-1:0]    drain_idx_r;
    logic                 push_s;
    sample_t              wr_sample_s;
    sample_t              rd_sample_s;
    logic                 pop_s;
    logic                 full_s;
    logic                 empty_s;
    logic                 drop_s;

    // Saturating add of one flit bit to a window count.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
        if (b && (a != {CNT_W{1'b1}})) begin
            return a + CNT_W'(1);
        end else begin
            return a;
        end
    endfunction

    assign snapshot_s = enable && (win_cnt_r == WIN_CNT_W'(WINDOW));

    // Event interval counter: restart on each event, report the finished interval.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_counter        <= EV_CNT_W'(1);
            ev_interval       <= {EV_CNT_W{1'b0}};
            ev_interval_valid <= 1'b0;
        end else if (enable) begin
            if (event_global) begin
                ev_interval       <= ev_counter;
                ev_interval_valid <= 1'b1;
                ev_counter        <= EV_CNT_W'(1);
            end else begin
                ev_interval_valid <= 1'b0;
                if (ev_counter != {EV_CNT_W{1'b1}}) begin
                    ev_counter <= ev_counter + EV_CNT_W'(1);
                end
            end
        end else begin
            ev_interval_valid <= 1'b0;
        end
    end

    // Window accumulation; the terminal cycle's flits land in the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_r       <= WIN_CNT_W'(1);
            win_id_r        <= {WIN_ID_W{1'b0}};
            shadow_win_id_r <= {WIN_ID_W{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i]    <= {CNT_W{1'b0}};
                shadow_r[i] <= {CNT_W{1'b0}};
            end
        end else if (enable) begin
            if (snapshot_s) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    shadow_r[i] <= sat_inc(acc_r[i], flit_valid[i]);
                    acc_r[i]    <= {CNT_W{1'b0}};
                end
                shadow_win_id_r <= win_id_r;
                win_id_r        <= win_id_r + WIN_ID_W'(1);
                win_cnt_r       <= WIN_CNT_W'(1);
            end else begin
                for (int i = 0; i < CHANNELS; i++) begin
                    acc_r[i] <= sat_inc(acc_r[i], flit_valid[i]);
                end
                win_cnt_r <= win_cnt_r + WIN_CNT_W'(1);
            end
        end
    end

    // Drain sequencer: one buffer write per channel after each snapshot,
    // independent of enable so a window is never half-written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            drain_idx_r <= {CHAN_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (snapshot_s) begin
                        state_r     <= ST_DRAIN;
                        drain_idx_r <= {CHAN_W{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    if (drain_idx_r == LAST_CHAN) begin
                        state_r     <= ST_IDLE;
                        drain_idx_r <= {CHAN_W{1'b0}};
                    end else begin
                        drain_idx_r <= drain_idx_r + CHAN_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    drain_idx_r <= {CHAN_W{1'b0}};
                end
            endcase
        end
    end

    // Build the sample record written while draining.
    always_comb begin
        push_s      = 1'b0;
        wr_sample_s = '0;
        if (state_r == ST_DRAIN) begin
            push_s             = 1'b1;
            wr_sample_s.chan   = CHAN_W_MAX'(drain_idx_r);
            wr_sample_s.count  = CNT_W_MAX'(shadow_r[drain_idx_r]);
            wr_sample_s.win_id = shadow_win_id_r;
        end else begin
            push_s      = 1'b0;
            wr_sample_s = '0;
        end
    end

    sample_ring_buf #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W),
        .MODE  (MODE)
    ) u_ring (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_data  (wr_sample_s),
        .pop        (pop_s),
        .rd_data    (rd_sample_s),
        .full       (full_s),
        .empty      (empty_s),
        .fill_level (fill_level),
        .drop       (drop_s)
    );

    assign smp_valid  = !empty_s;
    assign pop_s      = smp_valid && smp_ready;
    assign smp_chan   = rd_sample_s.chan[CHAN_W-1:0];
    assign smp_data   = rd_sample_s.count[CNT_W-1:0];
    assign smp_win_id = rd_sample_s.win_id;

    // Sticky overflow flag and saturating drop counter; clear wins over a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (clr_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 16'd0;
        end else if (drop_s) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_trafficmonitor_mc.sv
// Directed bench for trafficmonitor_mc: three instances (drop-newest,
// overwrite-oldest, narrow counters) share one stimulus stream.
module tb_trafficmonitor_mc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       event_global;
    logic       smp_ready;
    logic       clr_overflow;
    logic [3:0] flit_valid;

    always #5 clk = ~clk;

    // Instance A: DEPTH 8, drop newest
    logic [31:0] a_ev_counter, a_ev_interval;
    logic        a_ev_iv, a_smp_valid, a_ovf;
    logic [15:0] a_smp_data, a_win_id, a_drop;
    logic [1:0]  a_smp_chan;
    logic [3:0]  a_fill;
    // Instance B: DEPTH 8, overwrite oldest
    logic [31:0] b_ev_counter, b_ev_interval;
    logic        b_ev_iv, b_smp_valid, b_ovf;
    logic [15:0] b_smp_data, b_win_id, b_drop;
    logic [1:0]  b_smp_chan;
    logic [3:0]  b_fill;
    // Instance C: CNT_W 4, WINDOW 20, EV_CNT_W 6
    logic [5:0]  c_ev_counter, c_ev_interval;
    logic        c_ev_iv, c_smp_valid, c_ovf;
    logic [3:0]  c_smp_data;
    logic [15:0] c_win_id, c_drop;
    logic [1:0]  c_smp_chan;
    logic [3:0]  c_fill;

    trafficmonitor_mc #(.CHANNELS(4), .CNT_W(16), .WINDOW(50), .DEPTH(8), .EV_CNT_W(32), .OVERWRITE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_global(event_global), .flit_valid(flit_valid),
        .ev_counter(a_ev_counter), .ev_interval(a_ev_interval), .ev_interval_valid(a_ev_iv),
        .smp_valid(a_smp_valid), .smp_ready(smp_ready), .smp_data(a_smp_data), .smp_chan(a_smp_chan),
        .smp_win_id(a_win_id), .fill_level(a_fill), .overflow(a_ovf), .drop_count(a_drop),
        .clr_overflow(clr_overflow));

    trafficmonitor_mc #(.CHANNELS(4), .CNT_W(16), .WINDOW(50), .DEPTH(8), .EV_CNT_W(32), .OVERWRITE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_global(event_global), .flit_valid(flit_valid),
        .ev_counter(b_ev_counter), .ev_interval(b_ev_interval), .ev_interval_valid(b_ev_iv),
        .smp_valid(b_smp_valid), .smp_ready(smp_ready), .smp_data(b_smp_data), .smp_chan(b_smp_chan),
        .smp_win_id(b_win_id), .fill_level(b_fill), .overflow(b_ovf), .drop_count(b_drop),
        .clr_overflow(clr_overflow));

    trafficmonitor_mc #(.CHANNELS(4), .CNT_W(4), .WINDOW(20), .DEPTH(8), .EV_CNT_W(6), .OVERWRITE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .enable(enable), .event_global(event_global), .flit_valid(flit_valid),
        .ev_counter(c_ev_counter), .ev_interval(c_ev_interval), .ev_interval_valid(c_ev_iv),
        .smp_valid(c_smp_valid), .smp_ready(smp_ready), .smp_data(c_smp_data), .smp_chan(c_smp_chan),
        .smp_win_id(c_win_id), .fill_level(c_fill), .overflow(c_ovf), .drop_count(c_drop),
        .clr_overflow(clr_overflow));

    typedef struct {
        int chan;
        int count;
        int win;
    } smp_t;

    typedef struct {
        bit en;
        bit ev;
        int n;
        int exp_cnt;
        int exp_intv;
        bit exp_v;
    } ev_vec_t;

    smp_t    qa[$];
    smp_t    qb[$];
    smp_t    qc[$];
    ev_vec_t tbl[9];
    int      n_cmp = 0;
    int      n_bad = 0;

    // Capture every accepted sample of each instance
    always @(negedge clk) begin
        if (a_smp_valid && smp_ready) qa.push_back('{int'(a_smp_chan), int'(a_smp_data), int'(a_win_id)});
        if (b_smp_valid && smp_ready) qb.push_back('{int'(b_smp_chan), int'(b_smp_data), int'(b_win_id)});
        if (c_smp_valid && smp_ready) qc.push_back('{int'(c_smp_chan), int'(c_smp_data), int'(c_win_id)});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_smp(input string name, input smp_t s, input int c, input int n, input int w);
        chk({name, ".chan"}, 64'(s.chan), 64'(c));
        chk({name, ".count"}, 64'(s.count), 64'(n));
        chk({name, ".win"}, 64'(s.win), 64'(w));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ch0 always busy, ch2 every other cycle, ch1/ch3 idle
    task automatic run_pattern(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            flit_valid = {1'b0, k[0], 1'b0, 1'b1};
            @(posedge clk);
            #1;
        end
        flit_valid = 4'b0000;
    endtask

    // Expected count of channel c for the pattern over a 50-cycle window
    function automatic int exp_cnt50(input int c);
        return (c == 0) ? 50 : ((c == 2) ? 25 : 0);
    endfunction

    initial begin
        smp_t s;
        rst_n        = 1'b0;
        enable       = 1'b0;
        event_global = 1'b0;
        smp_ready    = 1'b0;
        clr_overflow = 1'b0;
        flit_valid   = 4'b0000;

        //           en ev  n  cnt intv v
        tbl[0] = '{1'b1, 1'b0, 9, 10, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1, 1, 10, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 1, 2, 10, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 5, 7, 10, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1, 1, 7, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 3, 1, 7, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 4, 5, 7, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 2, 5, 7, 1'b0};
        tbl[8] = '{1'b1, 1'b1, 1, 1, 5, 1'b1};

        // Reset state
        do_reset();
        chk("rst.ev_counter", 64'(a_ev_counter), 64'd1);
        chk("rst.ev_interval", 64'(a_ev_interval), 64'd0);
        chk("rst.ev_iv", 64'(a_ev_iv), 64'd0);
        chk("rst.smp_valid", 64'(a_smp_valid), 64'd0);
        chk("rst.fill", 64'(a_fill), 64'd0);
        chk("rst.overflow", 64'(a_ovf), 64'd0);
        chk("rst.drop", 64'(a_drop), 64'd0);
        chk("rst.win_id", 64'(a_win_id), 64'd0);

        // Event interval table
        for (int r = 0; r < 9; r++) begin
            enable       = tbl[r].en;
            event_global = tbl[r].ev;
            repeat (tbl[r].n) @(posedge clk);
            #1;
            chk($sformatf("ev[%0d].counter", r), 64'(a_ev_counter), 64'(tbl[r].exp_cnt));
            chk($sformatf("ev[%0d].interval", r), 64'(a_ev_interval), 64'(tbl[r].exp_intv));
            chk($sformatf("ev[%0d].valid", r), 64'(a_ev_iv), 64'(tbl[r].exp_v));
        end
        event_global = 1'b0;

        // Window counts with a free-running consumer, plus saturation on C
        enable    = 1'b1;
        smp_ready = 1'b1;
        do_reset();
        qa.delete();
        qc.delete();
        run_pattern(110);
        chk("win.qa_size", 64'(qa.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            s = (i < qa.size()) ? qa[i] : '{-1, -1, -1};
            chk_smp($sformatf("win.a[%0d]", i), s, i % 4, exp_cnt50(i % 4), i / 4);
        end
        chk("win.a_fill", 64'(a_fill), 64'd0);
        chk("win.a_ev_counter", 64'(a_ev_counter), 64'd111);
        chk("sat.c_ev_counter", 64'(c_ev_counter), 64'd63);
        s = (qc.size() > 0) ? qc[0] : '{-1, -1, -1};
        chk_smp("sat.c[0]", s, 0, 15, 0);
        s = (qc.size() > 2) ? qc[2] : '{-1, -1, -1};
        chk_smp("sat.c[2]", s, 2, 10, 0);

        // Three windows with a stalled consumer: drop-newest vs overwrite-oldest
        smp_ready = 1'b0;
        do_reset();
        run_pattern(160);
        chk("full.a_fill", 64'(a_fill), 64'd8);
        chk("full.a_ovf", 64'(a_ovf), 64'd1);
        chk("full.a_drop", 64'(a_drop), 64'd4);
        chk("full.b_fill", 64'(b_fill), 64'd8);
        chk("full.b_ovf", 64'(b_ovf), 64'd1);
        chk("full.b_drop", 64'(b_drop), 64'd4);
        enable = 1'b0;
        qa.delete();
        qb.delete();
        smp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        smp_ready = 1'b0;
        chk("read.qa_size", 64'(qa.size()), 64'd8);
        chk("read.qb_size", 64'(qb.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            s = (i < qa.size()) ? qa[i] : '{-1, -1, -1};
            chk_smp($sformatf("drop.a[%0d]", i), s, i % 4, exp_cnt50(i % 4), i / 4);
            s = (i < qb.size()) ? qb[i] : '{-1, -1, -1};
            chk_smp($sformatf("ovw.b[%0d]", i), s, i % 4, exp_cnt50(i % 4), 1 + i / 4);
        end
        chk("read.a_fill", 64'(a_fill), 64'd0);
        chk("read.b_ovf_sticky", 64'(b_ovf), 64'd1);
        clr_overflow = 1'b1;
        @(posedge clk);
        #1;
        clr_overflow = 1'b0;
        chk("clr.a_ovf", 64'(a_ovf), 64'd0);
        chk("clr.a_drop", 64'(a_drop), 64'd0);
        chk("clr.b_ovf", 64'(b_ovf), 64'd0);
        chk("clr.b_drop", 64'(b_drop), 64'd0);

        // Asynchronous reset in the middle of a drain
        enable = 1'b1;
        do_reset();
        run_pattern(52);
        chk("mid.a_fill", 64'(a_fill), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.smp_valid", 64'(a_smp_valid), 64'd0);
        chk("arst.fill", 64'(a_fill), 64'd0);
        chk("arst.ev_counter", 64'(a_ev_counter), 64'd1);
        chk("arst.win_id", 64'(a_win_id), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        qa.delete();
        smp_ready = 1'b1;
        run_pattern(60);
        chk("arst.qa_size", 64'(qa.size()), 64'd4);
        s = (qa.size() > 0) ? qa[0] : '{-1, -1, -1};
        chk_smp("arst.first", s, 0, 50, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trafficmonitor_mc.md
Name: trafficmonitor_mc

Overview:
Multi-channel successor to the single-link traffic monitor in the diagnosis system. It counts flit_valid per NoC channel over fixed windows and measures inter-event intervals of event_global. Each window's per-channel counts go into an on-chip ring buffer, which a host reads through a valid/ready stream. Buffer overflow is handled by a selectable mode: overwrite oldest, or drop newest.

Parameters:
CHANNELS, 4, number of monitored flit_valid inputs (1..16)
CNT_W, 16, width of per-channel window accumulators and sample data
WINDOW, 50, window length in cycles; must be >= CHANNELS+1
DEPTH, 64, ring buffer entries; power of two, >= 2
EV_CNT_W, 32, width of the event interval counter
OVERWRITE, 0, 1 = overwrite oldest entry on full; 0 = drop newest and flag overflow

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = counting active; 0 = window and event counters hold
event_global  in  1  event strobe
flit_valid  in  CHANNELS  per-channel flit valid
ev_counter  out  EV_CNT_W  running cycles since last event
ev_interval  out  EV_CNT_W  completed interval length
ev_interval_valid  out  1  one-cycle pulse with ev_interval
smp_valid  out  1  sample available
smp_ready  in  1  consumer accepts sample
smp_data  out  CNT_W  flit count of one channel for one window
smp_chan  out  $clog2(CHANNELS) (min 1)  channel index of smp_data
smp_win_id  out  16  window sequence number, wraps at 2^16
fill_level  out  $clog2(DEPTH)+1  entries held
overflow  out  1  sticky: a sample was dropped or overwritten
drop_count  out  16  dropped/overwritten samples, saturating
clr_overflow  in  1  clears overflow and drop_count

Behaviour:
- Reset values: ev_counter=1, ev_interval=0, ev_interval_valid=0, smp_valid=0, fill_level=0, overflow=0, drop_count=0, smp_win_id=0, window counter=1, accumulators=0, FSM=IDLE.
- Event path, enable=1:
  - event_global=1: ev_interval<=ev_counter, ev_interval_valid<=1 next cycle, ev_counter<=1.
  - Otherwise: ev_counter increments, saturating at all-ones.
- Event path, enable=0: ev_counter holds, and event_global is ignored.
- Window path, enable=1: each accumulator adds flit_valid[i], saturating at 2^CNT_W-1.
- Terminal window cycle (window counter==WINDOW):
  - Snapshot each channel as acc+flit_valid[i], saturated, into shadow regs.
  - Accumulators <=0, window counter <=1, win_id increments.
- Drain FSM: IDLE -> DRAIN on snapshot.
  - DRAIN writes one entry per cycle {chan, count, win_id} for chan 0..CHANNELS-1, then returns to IDLE.
  - DRAIN completes before the next snapshot, guaranteed by the WINDOW constraint.
  - DRAIN continues even if enable falls.
- Ring buffer read: smp_* is driven from the head entry. A pop occurs when smp_valid&&smp_ready; smp_valid=(fill_level!=0). Stream is first-word-fall-through.
- Full with a write and no pop:
  - OVERWRITE=1: oldest entry is discarded, the write is stored, fill_level is unchanged.
  - OVERWRITE=0: the write is discarded.
  - Both modes: overflow<=1, drop_count++.
- Full with simultaneous write and pop: both are accepted, with no drop.
- Empty with a write: the entry is visible as smp_valid on the next cycle, with no same-cycle bypass.
- clr_overflow has priority over a drop increment in the same cycle; that drop is lost from the count.
- Reset mid-drain: buffer contents, pointers and FSM are cleared, and no partial window survives.

Decomposition:
- Package trafficmonitor_pkg:
  - sample_t struct {chan, count, win_id}.
  - drop_mode enum.
  - Width helper constants (CHAN_W, PTR_W).
- Sub-module sample_ring_buf:
  - Parametrised DEPTH/width ring buffer with push, pop, full, empty, fill_level and overwrite-mode pointer handling.

Test Plan:
- Event interval: event_global at cycles 10 and 17 after reset, enable=1 -> ev_interval_valid pulses; second interval=7; ev_counter=1 the cycle after each event.
- Window counts: CHANNELS=4, WINDOW=50, ch0 always valid, ch2 every other cycle, ch1/ch3 idle, smp_ready=1 -> samples (0,50,0) (1,0,0) (2,25,0) (3,0,0), then win_id 1.
- Saturation: CNT_W=4, WINDOW=20, ch0 always valid -> count=15. Event counter forced near all-ones holds at max.
- Drop-newest: OVERWRITE=0, DEPTH=8, smp_ready=0 for 3 windows -> fill_level=8, overflow=1, drop_count=4; the first 8 samples read back are windows 0-1 intact.
- Overwrite-oldest: same stimulus with OVERWRITE=1 -> readout starts at window 1 ch0; windows 1-2 present; drop_count=4. clr_overflow then clears overflow and drop_count.
- Async reset: assert rst_n=0 mid-DRAIN between clock edges -> all outputs immediately at reset values; after release, the first sample has win_id=0.
